// File: rtl/hazard_ctrl_if.sv
// Bundles every signal between the pipeline datapath and the hazard controller.
// Latency: none, wires only.
// Backpressure: none; the controller's own stall/freeze outputs are the backpressure.
// Ports:
//   master - pipeline side: drives ID/EXE fields, branch/memStall status, clearCounters;
//            receives write enables, flushes, state and counters.
//   slave  - hazard controller side, the mirror of master.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       idRs;
    logic [4:0]       idRt;
    logic             idUsesRt;
    logic             exeMemRead;
    logic [4:0]       exeRt;
    logic             exeBranchTaken;
    logic             memStall;
    logic             clearCounters;
    logic             pcWrite;
    logic             ifIdWrite;
    logic             ifIdFlush;
    logic             idExeWrite;
    logic             idExeFlush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stallCount;
    logic [CNT_W-1:0] flushCount;
    logic [CNT_W-1:0] freezeCount;

    modport master (
        output idRs, idRt, idUsesRt, exeMemRead, exeRt, exeBranchTaken, memStall, clearCounters,
        input  pcWrite, ifIdWrite, ifIdFlush, idExeWrite, idExeFlush,
        input  state, stallCount, flushCount, freezeCount
    );

    modport slave (
        input  idRs, idRt, idUsesRt, exeMemRead, exeRt, exeBranchTaken, memStall, clearCounters,
        output pcWrite, ifIdWrite, ifIdFlush, idExeWrite, idExeFlush,
        output state, stallCount, flushCount, freezeCount
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch squash, memory freeze, debug counters.
// Latency: control outputs combinational (same cycle); state/counters one cycle later.
// Backpressure: memStall freezes PC, IF/ID and ID/EXE; a load-use hazard holds PC and IF/ID for one cycle.
// Ports:
//   clk, reset - pipeline clock, asynchronous active-high reset.
//   hz         - hazard_ctrl_if slave: ID/EXE hazard inputs in, pipeline register controls,
//                registered cycle class and saturating performance counters out.
module hazard_ctrl_unit #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2,
        FREEZE = 2'd3
    } cls_t;

    cls_t             state_q;
    cls_t             cls;
    logic             lu_haz;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] freeze_cnt;

    // Register 0 is hardwired, so a load to it can never create a dependency.
    assign lu_haz = hz.exeMemRead && (hz.exeRt != 5'd0) &&
                    ((hz.exeRt == hz.idRs) || (hz.idUsesRt && (hz.exeRt == hz.idRt)));

    // Cycle classification in priority order. A STALL is never repeated back to
    // back: after one bubble the load has left EXE, so a still-matching exeRt is stale.
    always_comb begin
        cls = RUN;
        if (hz.memStall) begin
            cls = FREEZE;
        end else if (hz.exeBranchTaken) begin
            cls = FLUSH;
        end else if (lu_haz && (state_q != STALL)) begin
            cls = STALL;
        end
    end

    always_comb begin
        hz.pcWrite    = 1'b1;
        hz.ifIdWrite  = 1'b1;
        hz.ifIdFlush  = 1'b0;
        hz.idExeWrite = 1'b1;
        hz.idExeFlush = 1'b0;
        unique case (cls)
            FREEZE: begin
                hz.pcWrite    = 1'b0;
                hz.ifIdWrite  = 1'b0;
                hz.idExeWrite = 1'b0;
            end
            FLUSH: begin
                hz.ifIdFlush  = 1'b1;
                hz.idExeFlush = 1'b1;
            end
            STALL: begin
                hz.pcWrite    = 1'b0;
                hz.ifIdWrite  = 1'b0;
                hz.idExeFlush = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides combinationally so the pipeline registers clear alongside us.
        if (reset) begin
            hz.pcWrite    = 1'b0;
            hz.ifIdWrite  = 1'b0;
            hz.ifIdFlush  = 1'b1;
            hz.idExeWrite = 1'b0;
            hz.idExeFlush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= cls;
        end
    end

    // Saturating counters; clear wins over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else if (hz.clearCounters) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if ((cls == STALL) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((cls == FLUSH) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if ((cls == FREEZE) && (freeze_cnt != '1)) begin
                freeze_cnt <= freeze_cnt + 1'b1;
            end
        end
    end

    assign hz.state       = state_q;
    assign hz.stallCount  = stall_cnt;
    assign hz.flushCount  = flush_cnt;
    assign hz.freezeCount = freeze_cnt;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus a randomized run
// against a cycle-class reference model. Two instances (16-bit and 2-bit counters)
// receive identical stimulus so saturation is exercised.
module tb_hazard_ctrl_unit;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) if16 ();
    hazard_ctrl_if #(.CNT_W(2))  if2  ();

    hazard_ctrl_unit #(.CNT_W(16)) dut16 (.clk(clk), .reset(reset), .hz(if16));
    hazard_ctrl_unit #(.CNT_W(2))  dut2  (.clk(clk), .reset(reset), .hz(if2));

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus for the next cycle.
    logic [4:0] s_rs, s_rt, s_ert;
    logic       s_uses, s_mrd, s_br, s_ms, s_clr, s_reset;

    // Model state: previous cycle class (0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE), counters.
    int          m_state;
    logic [15:0] m16 [3];
    logic [1:0]  m2  [3];
    int          exp_cls;
    logic [4:0]  exp_ctrl;

    // Observations; control vector is {pcWrite, ifIdWrite, ifIdFlush, idExeWrite, idExeFlush}.
    logic [4:0]  obs_ctrl, obs_ctrl2;
    logic [1:0]  obs_state, obs_state2;
    logic [15:0] o16 [3];
    logic [1:0]  o2  [3];

    task automatic idle();
        s_rs = 0; s_rt = 0; s_ert = 0;
        s_uses = 0; s_mrd = 0; s_br = 0; s_ms = 0; s_clr = 0; s_reset = 0;
    endtask

    task automatic apply();
        reset = s_reset;
        if16.idRs = s_rs; if16.idRt = s_rt; if16.idUsesRt = s_uses; if16.exeMemRead = s_mrd;
        if16.exeRt = s_ert; if16.exeBranchTaken = s_br; if16.memStall = s_ms; if16.clearCounters = s_clr;
        if2.idRs = s_rs; if2.idRt = s_rt; if2.idUsesRt = s_uses; if2.exeMemRead = s_mrd;
        if2.exeRt = s_ert; if2.exeBranchTaken = s_br; if2.memStall = s_ms; if2.clearCounters = s_clr;
    endtask

    // Cycle class and control vector from the hazard rules.
    task automatic model_class();
        bit lu;
        lu = s_mrd && s_ert != 0 && (s_ert == s_rs || (s_uses && s_ert == s_rt));
        if (s_ms)                    exp_cls = 3;
        else if (s_br)               exp_cls = 2;
        else if (lu && m_state != 1) exp_cls = 1;
        else                         exp_cls = 0;
        case (exp_cls)
            0: exp_ctrl = 5'b11010;
            1: exp_ctrl = 5'b00011;
            2: exp_ctrl = 5'b11111;
            default: exp_ctrl = 5'b00000;
        endcase
        if (s_reset) exp_ctrl = 5'b00101;
    endtask

    task automatic model_update();
        if (s_reset) begin
            m_state = 0;
            for (int i = 0; i < 3; i++) begin m16[i] = 0; m2[i] = 0; end
        end else begin
            m_state = exp_cls;
            if (s_clr) begin
                for (int i = 0; i < 3; i++) begin m16[i] = 0; m2[i] = 0; end
            end else if (exp_cls != 0) begin
                if (m16[exp_cls-1] != 16'hFFFF) m16[exp_cls-1] = m16[exp_cls-1] + 1;
                if (m2[exp_cls-1]  != 2'b11)    m2[exp_cls-1]  = m2[exp_cls-1] + 1;
            end
        end
    endtask

    // One pipeline cycle: inputs applied 1ns after the edge, controls sampled
    // mid-cycle, registered outputs sampled 1ns after the next edge.
    task automatic tick();
        apply();
        #3;
        obs_ctrl  = {if16.pcWrite, if16.ifIdWrite, if16.ifIdFlush, if16.idExeWrite, if16.idExeFlush};
        obs_ctrl2 = {if2.pcWrite, if2.ifIdWrite, if2.ifIdFlush, if2.idExeWrite, if2.idExeFlush};
        model_class();
        @(posedge clk);
        model_update();
        #1;
        obs_state  = if16.state;
        obs_state2 = if2.state;
        o16[0] = if16.stallCount; o16[1] = if16.flushCount; o16[2] = if16.freezeCount;
        o2[0]  = if2.stallCount;  o2[1]  = if2.flushCount;  o2[2]  = if2.freezeCount;
    endtask

    task automatic clear_cnt();
        idle(); s_clr = 1; tick(); idle();
    endtask

    task automatic test_reset();
        idle(); s_reset = 1;
        tick();
        n_checks++; if (obs_ctrl !== 5'b00101) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=%b", obs_ctrl, 5'b00101); end
        n_checks++; if (obs_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", obs_state); end
        n_checks++; if (o16[0] !== 16'd0 || o16[1] !== 16'd0 || o16[2] !== 16'd0) begin
            n_fail++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", o16[0], o16[1], o16[2]); end
        idle(); tick();
        // Build up stallCount=5: a held hazard alternates STALL and RUN.
        s_mrd = 1; s_ert = 8; s_rs = 8;
        for (int i = 0; i < 9; i++) tick();
        n_checks++; if (o16[0] !== 16'd5) begin n_fail++; $display("FAIL reset_prestall got=%0d exp=5", o16[0]); end
        s_reset = 1; tick();
        n_checks++; if (obs_ctrl !== 5'b00101) begin n_fail++; $display("FAIL reset_midrun_ctrl got=%b exp=%b", obs_ctrl, 5'b00101); end
        n_checks++; if (o16[0] !== 16'd0) begin n_fail++; $display("FAIL reset_midrun_stall got=%0d exp=0", o16[0]); end
        idle(); tick();
        n_checks++; if (obs_state !== 2'd0 || o16[0] !== 16'd0 || o16[1] !== 16'd0 || o16[2] !== 16'd0) begin
            n_fail++; $display("FAIL reset_release got state=%0d cnt=%0d/%0d/%0d exp 0,0/0/0", obs_state, o16[0], o16[1], o16[2]); end
    endtask

    task automatic test_load_use_rs();
        clear_cnt();
        s_mrd = 1; s_ert = 8; s_rs = 8;
        tick();
        n_checks++; if (obs_ctrl !== 5'b00011) begin n_fail++; $display("FAIL lu_rs_ctrl got=%b exp=%b", obs_ctrl, 5'b00011); end
        n_checks++; if (obs_state !== 2'd1 || o16[0] !== 16'd1) begin
            n_fail++; $display("FAIL lu_rs_state got state=%0d stall=%0d exp 1,1", obs_state, o16[0]); end
        tick();
        n_checks++; if (obs_ctrl !== 5'b11010) begin n_fail++; $display("FAIL lu_guard_ctrl got=%b exp=%b", obs_ctrl, 5'b11010); end
        n_checks++; if (obs_state !== 2'd0 || o16[0] !== 16'd1) begin
            n_fail++; $display("FAIL lu_guard_state got state=%0d stall=%0d exp 0,1", obs_state, o16[0]); end
        s_ert = 0; s_rs = 0;
        tick();
        n_checks++; if (obs_ctrl !== 5'b11010) begin n_fail++; $display("FAIL lu_r0_ctrl got=%b exp=%b", obs_ctrl, 5'b11010); end
        idle();
    endtask

    task automatic test_rt_dependency();
        clear_cnt();
        s_mrd = 1; s_ert = 9; s_rt = 9; s_rs = 1; s_uses = 0;
        tick();
        n_checks++; if (obs_ctrl !== 5'b11010) begin n_fail++; $display("FAIL rt_unused_ctrl got=%b exp=%b", obs_ctrl, 5'b11010); end
        s_uses = 1;
        tick();
        n_checks++; if (obs_ctrl !== 5'b00011) begin n_fail++; $display("FAIL rt_used_ctrl got=%b exp=%b", obs_ctrl, 5'b00011); end
        n_checks++; if (obs_state !== 2'd1) begin n_fail++; $display("FAIL rt_used_state got=%0d exp=1", obs_state); end
        idle();
    endtask

    task automatic test_branch_vs_lu();
        clear_cnt();
        s_mrd = 1; s_ert = 5; s_rs = 5; s_br = 1;
        tick();
        n_checks++; if (obs_ctrl !== 5'b11111) begin n_fail++; $display("FAIL br_lu_ctrl got=%b exp=%b", obs_ctrl, 5'b11111); end
        n_checks++; if (obs_state !== 2'd2 || o16[1] !== 16'd1 || o16[0] !== 16'd0) begin
            n_fail++; $display("FAIL br_lu_counts got state=%0d flush=%0d stall=%0d exp 2,1,0", obs_state, o16[1], o16[0]); end
        idle();
    endtask

    task automatic test_freeze();
        clear_cnt();
        s_ms = 1; s_br = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (obs_ctrl !== 5'b00000) begin n_fail++; $display("FAIL freeze_ctrl cyc%0d got=%b exp=%b", i, obs_ctrl, 5'b00000); end
        end
        n_checks++; if (o16[2] !== 16'd3 || obs_state !== 2'd3) begin
            n_fail++; $display("FAIL freeze_count got freeze=%0d state=%0d exp 3,3", o16[2], obs_state); end
        s_ms = 0;
        tick();
        n_checks++; if (obs_ctrl !== 5'b11111) begin n_fail++; $display("FAIL freeze_exit_ctrl got=%b exp=%b", obs_ctrl, 5'b11111); end
        n_checks++; if (o16[1] !== 16'd1 || obs_state !== 2'd2) begin
            n_fail++; $display("FAIL freeze_exit_flush got flush=%0d state=%0d exp 1,2", o16[1], obs_state); end
        idle();
    endtask

    task automatic test_saturation_clear();
        clear_cnt();
        s_ms = 1;
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (o2[2] !== 2'd3) begin n_fail++; $display("FAIL sat_freeze2 got=%0d exp=3", o2[2]); end
        n_checks++; if (o16[2] !== 16'd5) begin n_fail++; $display("FAIL sat_freeze16 got=%0d exp=5", o16[2]); end
        s_clr = 1;
        tick();
        n_checks++; if (o2[2] !== 2'd0 || o16[2] !== 16'd0 || o16[0] !== 16'd0 || o16[1] !== 16'd0) begin
            n_fail++; $display("FAIL clear_prio got freeze2=%0d freeze16=%0d exp 0,0", o2[2], o16[2]); end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            s_rs    = 5'($urandom_range(0, 3));
            s_rt    = 5'($urandom_range(0, 3));
            s_ert   = 5'($urandom_range(0, 3));
            s_uses  = 1'($urandom_range(0, 1));
            s_mrd   = 1'($urandom_range(0, 1));
            s_br    = ($urandom_range(0, 5) == 0);
            s_ms    = ($urandom_range(0, 4) == 0);
            s_clr   = ($urandom_range(0, 29) == 0);
            s_reset = ($urandom_range(0, 59) == 0);
            tick();
            n_checks++; if (obs_ctrl !== exp_ctrl || obs_ctrl2 !== exp_ctrl) begin
                n_fail++; $display("FAIL rnd_ctrl n=%0d got=%b/%b exp=%b", n, obs_ctrl, obs_ctrl2, exp_ctrl); end
            n_checks++; if (obs_state !== 2'(m_state) || obs_state2 !== 2'(m_state)) begin
                n_fail++; $display("FAIL rnd_state n=%0d got=%0d/%0d exp=%0d", n, obs_state, obs_state2, m_state); end
            for (int k = 0; k < 3; k++) begin
                n_checks++; if (o16[k] !== m16[k] || o2[k] !== m2[k]) begin
                    n_fail++; $display("FAIL rnd_cnt%0d n=%0d got=%0d/%0d exp=%0d/%0d", k, n, o16[k], o2[k], m16[k], m2[k]); end
            end
        end
        idle();
    endtask

    initial begin
        m_state = 0;
        for (int i = 0; i < 3; i++) begin m16[i] = 0; m2[i] = 0; end
        idle(); s_reset = 1; apply();
        @(posedge clk); #1;
        test_reset();
        test_load_use_rs();
        test_rt_dependency();
        test_branch_vs_lu();
        test_freeze();
        test_saturation_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
